// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, addresses the synchronous instruction ROM and
// loads the F/D latch. Redirects flush F/D; stalls freeze PC, ROM address and F/D.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 12
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_q,
  output logic [31:0]        fd_insn,
  output logic [31:0]        fd_pc,
  output logic               fd_valid
);

  logic [31:0] pcF;
  logic        fValid;
  logic [31:0] pcPlus1;
  logic [31:0] nextPc;

  assign pcPlus1 = pcF + 32'd1;

  // The reset term keeps the ROM address at RESET_PC while reset is held,
  // even if a stale redirect is still asserted.
  always_comb begin
    nextPc = pcPlus1;
    if (!resetn)               nextPc = RESET_PC;
    else if (redirect)         nextPc = redirect_pc;
    else if (!fValid || stall) nextPc = pcF;
  end

  assign imem_addr = nextPc[IMEM_AW-1:0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pcF      <= RESET_PC;
      fValid   <= 1'b0;
      fd_insn  <= 32'h0;
      fd_pc    <= 32'h0;
      fd_valid <= 1'b0;
    end else begin
      pcF    <= nextPc;
      fValid <= 1'b1;
      if (redirect) begin
        fd_insn  <= 32'h0;
        fd_pc    <= 32'h0;
        fd_valid <= 1'b0;
      end else if (!stall) begin
        if (!fValid) begin
          fd_insn  <= 32'h0;
          fd_pc    <= 32'h0;
          fd_valid <= 1'b0;
        end else begin
          fd_insn  <= imem_q;
          fd_pc    <= pcPlus1;
          fd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences,
// and random stimulus against a ROM-content reference model (two ROM widths).
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic [11:0] imemAddr;
  logic [3:0]  imemAddrW;
  logic [31:0] imemQ, imemQW;
  logic [31:0] fdInsn, fdPc, fdInsnW, fdPcW;
  logic        fdValid, fdValidW;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  // ROM contents: mem[i] = 32'h1000_0000 + i
  always @(posedge clock) begin
    imemQ  <= 32'h1000_0000 + {20'd0, imemAddr};
    imemQW <= 32'h1000_0000 + {28'd0, imemAddrW};
  end

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(12)) dut (
    .clock(clock), .resetn(resetn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirectPc), .imem_addr(imemAddr), .imem_q(imemQ),
    .fd_insn(fdInsn), .fd_pc(fdPc), .fd_valid(fdValid));

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(4)) dutW (
    .clock(clock), .resetn(resetn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirectPc), .imem_addr(imemAddrW), .imem_q(imemQW),
    .fd_insn(fdInsnW), .fd_pc(fdPcW), .fd_valid(fdValidW));

  // Reference model: index 0 = 12-bit ROM, index 1 = 4-bit ROM
  logic [31:0] mPc[2], mInsn[2], mFdPc[2];
  logic        mFv[2], mFdV[2];
  logic [31:0] lastAddr, lastAddrW;

  function automatic logic [31:0] memWord(int k, logic [31:0] a);
    return 32'h1000_0000 + (a % ((k == 0) ? 32'd4096 : 32'd16));
  endfunction

  function automatic logic [31:0] mNext(int k);
    if (redirect) return redirectPc;
    if (!mFv[k] || stall) return mPc[k];
    return mPc[k] + 32'd1;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mPc[k] = 32'h0; mFv[k] = 1'b0;
      mInsn[k] = 32'h0; mFdPc[k] = 32'h0; mFdV[k] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] nxt;
      nxt = mNext(k);
      if (redirect) begin
        mInsn[k] = 32'h0; mFdPc[k] = 32'h0; mFdV[k] = 1'b0;
      end else if (!stall) begin
        if (!mFv[k]) begin
          mInsn[k] = 32'h0; mFdPc[k] = 32'h0; mFdV[k] = 1'b0;
        end else begin
          mInsn[k] = memWord(k, mPc[k]); mFdPc[k] = mPc[k] + 32'd1; mFdV[k] = 1'b1;
        end
      end
      mPc[k] = nxt;
      mFv[k] = 1'b1;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOut();
    check("fd_insn",    fdInsn,           mInsn[0]);
    check("fd_pc",      fdPc,             mFdPc[0]);
    check("fd_valid",   {31'd0, fdValid}, {31'd0, mFdV[0]});
    check("fd_insn_w",  fdInsnW,          mInsn[1]);
    check("fd_pc_w",    fdPcW,            mFdPc[1]);
    check("fd_valid_w", {31'd0, fdValidW}, {31'd0, mFdV[1]});
  endtask

  // One cycle: inputs at negedge, address check before the edge, outputs after
  task automatic cyc(logic st, logic rd, logic [31:0] rpc);
    @(negedge clock);
    stall = st; redirect = rd; redirectPc = rpc;
    #1;
    lastAddr = {20'd0, imemAddr};
    lastAddrW = {28'd0, imemAddrW};
    check("imem_addr",   lastAddr,  mNext(0) & 32'hFFF);
    check("imem_addr_w", lastAddrW, mNext(1) & 32'hF);
    @(posedge clock);
    #1;
    modelEdge();
    checkOut();
  endtask

  task automatic doReset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    modelReset();
    checkOut();
    check("rst_addr",   {20'd0, imemAddr},  32'h0);
    check("rst_addr_w", {28'd0, imemAddrW}, 32'h0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        st, rd;
    logic [31:0] rpc, addr, insn, pc;
    logic        v;
  } vec_t;

  vec_t vec[18];

  initial begin
    vec[0]  = '{1'b0, 1'b0, 32'h0,  32'h0,  32'h0,         32'h0,  1'b0};
    vec[1]  = '{1'b0, 1'b0, 32'h0,  32'h1,  32'h1000_0000, 32'h1,  1'b1};
    vec[2]  = '{1'b0, 1'b0, 32'h0,  32'h2,  32'h1000_0001, 32'h2,  1'b1};
    vec[3]  = '{1'b0, 1'b0, 32'h0,  32'h3,  32'h1000_0002, 32'h3,  1'b1};
    vec[4]  = '{1'b0, 1'b0, 32'h0,  32'h4,  32'h1000_0003, 32'h4,  1'b1};
    vec[5]  = '{1'b0, 1'b0, 32'h0,  32'h5,  32'h1000_0004, 32'h5,  1'b1};
    vec[6]  = '{1'b1, 1'b0, 32'h0,  32'h5,  32'h1000_0004, 32'h5,  1'b1};
    vec[7]  = '{1'b1, 1'b0, 32'h0,  32'h5,  32'h1000_0004, 32'h5,  1'b1};
    vec[8]  = '{1'b1, 1'b0, 32'h0,  32'h5,  32'h1000_0004, 32'h5,  1'b1};
    vec[9]  = '{1'b0, 1'b0, 32'h0,  32'h6,  32'h1000_0005, 32'h6,  1'b1};
    vec[10] = '{1'b0, 1'b0, 32'h0,  32'h7,  32'h1000_0006, 32'h7,  1'b1};
    vec[11] = '{1'b0, 1'b0, 32'h0,  32'h8,  32'h1000_0007, 32'h8,  1'b1};
    vec[12] = '{1'b0, 1'b1, 32'h40, 32'h40, 32'h0,         32'h0,  1'b0};
    vec[13] = '{1'b0, 1'b0, 32'h0,  32'h41, 32'h1000_0040, 32'h41, 1'b1};
    vec[14] = '{1'b1, 1'b1, 32'h20, 32'h20, 32'h0,         32'h0,  1'b0};
    vec[15] = '{1'b1, 1'b0, 32'h0,  32'h20, 32'h0,         32'h0,  1'b0};
    vec[16] = '{1'b0, 1'b0, 32'h0,  32'h21, 32'h1000_0020, 32'h21, 1'b1};
    vec[17] = '{1'b0, 1'b0, 32'h0,  32'h22, 32'h1000_0021, 32'h22, 1'b1};

    doReset();
    for (int i = 0; i < 18; i++) begin
      cyc(vec[i].st, vec[i].rd, vec[i].rpc);
      check($sformatf("vec%0d_addr", i),  lastAddr,            vec[i].addr);
      check($sformatf("vec%0d_insn", i),  fdInsn,              vec[i].insn);
      check($sformatf("vec%0d_pc", i),    fdPc,                vec[i].pc);
      check($sformatf("vec%0d_valid", i), {31'd0, fdValid},    {31'd0, vec[i].v});
    end

    // 4-bit ROM address wraps while fd_pc keeps counting
    doReset();
    for (int k = 1; k <= 18; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      if (k == 17) begin
        check("wrap_addr", lastAddrW, 32'h0);
        check("wrap_pc16", fdPcW,     32'd16);
        check("wrap_insnF", fdInsnW,  32'h1000_000F);
      end
      if (k == 18) begin
        check("wrap_insn0", fdInsnW, 32'h1000_0000);
        check("wrap_pc17",  fdPcW,   32'd17);
      end
    end

    // Asynchronous reset mid-stall, then a clean restart
    cyc(1'b1, 1'b0, 32'h0);
    @(negedge clock);
    stall = 1'b1; redirect = 1'b0;
    #2 resetn = 1'b0;
    #1;
    modelReset();
    check("async_insn",  fdInsn,            32'h0);
    check("async_pc",    fdPc,              32'h0);
    check("async_valid", {31'd0, fdValid},  32'h0);
    check("async_addr",  {20'd0, imemAddr}, 32'h0);
    @(posedge clock);
    #1 resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(vec[i].st, vec[i].rd, vec[i].rpc);
      check($sformatf("restart%0d_insn", i),  fdInsn,           vec[i].insn);
      check($sformatf("restart%0d_pc", i),    fdPc,             vec[i].pc);
      check($sformatf("restart%0d_valid", i), {31'd0, fdValid}, {31'd0, vec[i].v});
    end

    // Redirect in the first cycle after reset: RESET_PC is never delivered
    doReset();
    cyc(1'b0, 1'b1, 32'h33);
    check("first_redir_valid", {31'd0, fdValid}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    check("first_redir_insn", fdInsn, 32'h1000_0033);
    check("first_redir_pc",   fdPc,   32'h34);

    // Random stimulus against the model, including PC wrap near 2^32
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + $urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 99) < 2) begin
        redirect = $urandom_range(0, 1) == 1;
        redirectPc = rpc;
        doReset();
      end else begin
        cyc($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15, rpc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
